// File: rtl/prbs_pkg.sv
// Shared constants and the word-advance function for the PRBS23 generator.
// Polynomial x^23 + x^18 + 1, Fibonacci form, 17 serial steps per output word.
package prbs_pkg;

  localparam int unsigned StateW = 23;
  localparam int unsigned WordW  = 17;
  localparam int unsigned TapA   = 23;
  localparam int unsigned TapB   = 18;

  localparam logic [StateW-1:0] DefaultSeed = 23'h7FFFFF;

  // Fallback used whenever a load would otherwise put the LFSR in its all-zero lock-up state.
  function automatic logic [StateW-1:0] prbs_load_value(input logic [StateW-1:0] seed);
    return (seed == '0) ? DefaultSeed : seed;
  endfunction

  // Unrolled serial steps: b = s[22] ^ s[17]; s = {s[21:0], b}. The first generated bit
  // ends up in bit WordW-1, the last one in bit 0.
  function automatic logic [StateW-1:0] prbs_advance(input logic [StateW-1:0] s);
    logic [StateW-1:0] t;
    t = s;
    for (int i = 0; i < int'(WordW); i++) begin
      t = {t[StateW-2:0], t[TapA-1] ^ t[TapB-1]};
    end
    return t;
  endfunction

endpackage

// File: rtl/prbs.sv
// PRBS23 word generator.
// Produces one 17-bit word of the x^23 + x^18 + 1 stream per enabled clock.
// Ports:
//   clk   - clock, all logic rising-edge
//   reset - synchronous active-high reset, loads SEED and clears data
//   en    - advance one word per clock while high
//   init  - synchronous reload of SEED and clear of data (below reset in priority)
//   data  - registered word, bit 16 oldest stream bit, bit 0 newest
module prbs
  import prbs_pkg::*;
#(
  parameter logic [22:0] SEED = 23'h7FFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        init,
  output logic [16:0] data
);

  localparam logic [StateW-1:0] LoadSeed = prbs_load_value(SEED);

  logic [StateW-1:0] state_q, state_d;
  logic [WordW-1:0]  data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (init) begin
      state_d = LoadSeed;
      data_d  = '0;
    end else if (en) begin
      // All-zero state never leaves itself; restart from the fallback seed instead.
      state_d = (state_q == '0) ? DefaultSeed : prbs_advance(state_q);
      data_d  = state_d[WordW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LoadSeed;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: tb/tb_prbs.sv
// Self-checking bench for prbs: a fixed vector table on a SEED=1 instance, randomized
// stimulus on a default-seed instance against a stream-recurrence model, and a group of
// instances covering the zero-seed fallback and distinct-seed streams.
module tb_prbs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Instance with SEED = 1 (table-driven).
  logic        r1, i1, e1;
  logic [16:0] d1;
  prbs #(.SEED(23'h000001)) u_seed1 (.clk(clk), .reset(r1), .en(e1), .init(i1), .data(d1));

  // Default-seed instance (random stimulus).
  logic        rd, id, ed;
  logic [16:0] dd;
  prbs u_def (.clk(clk), .reset(rd), .en(ed), .init(id), .data(dd));

  // Group sharing controls: zero seed plus three distinct seeds.
  logic        rg, ig, eg;
  logic [16:0] dz, da, db, dc;
  prbs #(.SEED(23'h000000)) u_zero (.clk(clk), .reset(rg), .en(eg), .init(ig), .data(dz));
  prbs #(.SEED(23'h7FF801)) u_a    (.clk(clk), .reset(rg), .en(eg), .init(ig), .data(da));
  prbs #(.SEED(23'h7FF802)) u_b    (.clk(clk), .reset(rg), .en(eg), .init(ig), .data(db));
  prbs #(.SEED(23'h7FF804)) u_c    (.clk(clk), .reset(rg), .en(eg), .init(ig), .data(dc));

  typedef struct {
    logic        rst;
    logic        ini;
    logic        en;
    logic [16:0] data;
    logic [22:0] state;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [22:0] act, input logic [22:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: the stream obeys x[n] = x[n-23] ^ x[n-18]. "last" holds the 23 most recent
  // stream bits, oldest in the MSB. Builds the 40-bit window and takes the last 23/17.
  task automatic model_adv(input logic [22:0] last, output logic [22:0] nlast,
                           output logic [16:0] word);
    bit x[40];
    if (last == 23'h0) begin
      nlast = 23'h7FFFFF;
      word  = 17'h1FFFF;
      return;
    end
    for (int k = 0; k < 23; k++) x[k] = last[22-k];
    for (int n = 23; n < 40; n++) x[n] = x[n-23] ^ x[n-18];
    for (int k = 0; k < 23; k++) nlast[22-k] = x[17+k];
    for (int k = 0; k < 17; k++) word[16-k] = x[23+k];
  endtask

  function automatic logic [22:0] model_load(input logic [22:0] seed);
    return (seed == 23'h0) ? 23'h7FFFFF : seed;
  endfunction

  logic [22:0] m_state;
  logic [16:0] m_data;

  // Applies one cycle of control to the default-seed instance and its model, then checks.
  task automatic def_cycle(input logic r, input logic i, input logic e, input string name);
    logic [22:0] ns;
    logic [16:0] w;
    rd = r; id = i; ed = e;
    tick();
    if (r || i) begin
      m_state = model_load(23'h7FFFFF);
      m_data  = 17'h0;
    end else if (e) begin
      model_adv(m_state, ns, w);
      m_state = ns;
      m_data  = w;
    end
    chk({name, "_data"}, {6'h0, dd}, {6'h0, m_data});
    chk({name, "_state"}, u_def.state_q, m_state);
  endtask

  initial begin
    logic [22:0] ms [3];
    logic [16:0] md [3];
    logic [22:0] ns;
    logic [16:0] w;
    logic [22:0] first_state;
    int          diff;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 17'h00000, 23'h000001};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 17'h00000, 23'h020000};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 17'h10800, 23'h010800};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 17'h10800, 23'h010800};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 17'h00000, 23'h000001};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 17'h00000, 23'h020000};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 17'h00000, 23'h000001};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 17'h00000, 23'h000001};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 17'h00000, 23'h020000};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 17'h10800, 23'h010800};

    r1 = 1'b0; i1 = 1'b0; e1 = 1'b0;
    rd = 1'b1; id = 1'b0; ed = 1'b0;
    rg = 1'b1; ig = 1'b0; eg = 1'b0;
    @(negedge clk);

    // Table on the SEED=1 instance.
    for (int v = 0; v < 10; v++) begin
      r1 = vecs[v].rst; i1 = vecs[v].ini; e1 = vecs[v].en;
      tick();
      chk($sformatf("vec%0d_data", v), {6'h0, d1}, {6'h0, vecs[v].data});
      chk($sformatf("vec%0d_state", v), u_seed1.state_q, vecs[v].state);
    end
    r1 = 1'b0; i1 = 1'b0; e1 = 1'b0;

    // Default seed: reset, then en toggle 1,0,0,1.
    def_cycle(1'b1, 1'b0, 1'b0, "def_reset");
    def_cycle(1'b0, 1'b0, 1'b1, "tog1");
    def_cycle(1'b0, 1'b0, 1'b0, "tog0a");
    def_cycle(1'b0, 1'b0, 1'b0, "tog0b");
    def_cycle(1'b0, 1'b0, 1'b1, "tog1b");

    // Init mid-stream must replay the post-reset words.
    first_state = m_state;
    def_cycle(1'b0, 1'b1, 1'b1, "init_mid");
    def_cycle(1'b0, 1'b0, 1'b1, "replay1");
    def_cycle(1'b0, 1'b0, 1'b1, "replay2");
    chk("replay_state", u_def.state_q, first_state);

    // Randomized control stream.
    for (int c = 0; c < 4000; c++) begin
      def_cycle(($urandom % 200) == 0, ($urandom % 97) == 0, ($urandom % 4) != 0, "rand");
    end
    // Long uninterrupted run.
    for (int c = 0; c < 3000; c++) def_cycle(1'b0, 1'b0, 1'b1, "run");
    rd = 1'b0; id = 1'b0; ed = 1'b0;

    // Group: reset with init and en high together.
    rg = 1'b1; ig = 1'b1; eg = 1'b1;
    tick();
    chk("zero_seed_state", u_zero.state_q, 23'h7FFFFF);
    chk("zero_seed_data", {6'h0, dz}, 23'h0);
    chk("a_reset_data", {6'h0, da}, 23'h0);
    chk("a_reset_state", u_a.state_q, 23'h7FF801);
    ms[0] = 23'h7FF801; ms[1] = 23'h7FF802; ms[2] = 23'h7FF804;
    rg = 1'b0; ig = 1'b0; eg = 1'b1;
    diff = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        model_adv(ms[k], ns, w);
        ms[k] = ns;
        md[k] = w;
      end
      chk("grp_a", {6'h0, da}, {6'h0, md[0]});
      chk("grp_b", {6'h0, db}, {6'h0, md[1]});
      chk("grp_c", {6'h0, dc}, {6'h0, md[2]});
      if (da != db && db != dc && da != dc) diff++;
    end
    n_chk++;
    if (diff < 50) begin
      n_fail++;
      $display("FAIL grp_distinct: got %0d distinct cycles expected at least 50", diff);
    end
    eg = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs.md
PRBS -- requirements
Module: prbs

Interface
REQ-001 SHALL have parameter SEED, 23-bit, default 23'h7FFFFF; it is the LFSR state loaded on reset and init.
REQ-002 SHALL have port clk, input, 1 bit; the single clock, all logic rising-edge.
REQ-003 SHALL have port reset, input, 1 bit; synchronous, active-high reset.
REQ-004 SHALL have port en, input, 1 bit; when high, the generator advances one word per clock.
REQ-005 SHALL have port init, input, 1 bit; synchronous reload of SEED, active-high.
REQ-006 SHALL have port data, output, 17 bits; registered pseudo-random word.

Function
REQ-007 SHALL implement PRBS23 polynomial x^23 + x^18 + 1 as a 23-bit Fibonacci LFSR, state s[22:0].
REQ-008 One serial step SHALL be: b = s[22] XOR s[17]; s <= {s[21:0], b}.
REQ-009 Each clock with en=1 (and reset=0, init=0) SHALL apply exactly 17 serial steps, computed combinationally in a single cycle.
REQ-010 data SHALL be registered as the new state bits [16:0] on the same edge as the state update, with zero added latency.
REQ-011 data bit 16 SHALL hold the oldest (first-generated) bit of the 17; bit 0 SHALL hold the newest.
REQ-012 Successive words SHALL be disjoint, contiguous 17-bit segments of the serial PRBS23 stream.
REQ-013 With en=0, state and data SHALL hold their values.
REQ-014 init=1 SHALL load s <= SEED and data <= 0 on that edge, regardless of en.
REQ-015 Priority SHALL be reset > init > en.
REQ-016 If SEED == 0, any load (reset or init) SHALL substitute 23'h7FFFFF.
REQ-017 If the state is ever all-zero while en=1, the next state SHALL be 23'h7FFFFF; this is the lock-up guard.
REQ-018 data SHALL be interpreted by consumers as either unsigned or two's-complement; the block itself attaches no sign.

Reset
REQ-019 On reset=1 at a rising edge: s <= SEED (subject to REQ-016) and data <= 17'h00000.
REQ-020 Reset asserted mid-stream SHALL take effect on that edge, with no residual state.
REQ-021 The first enabled cycle after reset SHALL produce the first 17 stream bits following SEED.

Structure
REQ-022 Polynomial taps (23, 18), state width 23, word width 17 and the default/fallback seed SHALL be constants in a shared package, prbs_pkg.
REQ-023 The 17-step advance SHALL be a function (package or local) that unrolls the serial step; no sub-module is required.
REQ-024 A single flat module SHALL be used: state register, data register, next-state function.

Verification
REQ-025 SEED=23'h000001, reset, then en=1 for 2 cycles -> data=17'h00000 (state 23'h020000), then data=17'h10800 (state 23'h010800).
REQ-026 Default SEED, en=1 for 2^23-1 words; compare against a bit-serial reference model -> every word matches, and the state returns to SEED after 17*(2^23-1) serial steps.
REQ-027 en toggled 1,0,0,1 -> data and state hold during en=0, and the sequence resumes without skipping.
REQ-028 init pulse mid-stream with en=1 -> next data=0 and state=SEED; the sequence then repeats the post-reset words exactly.
REQ-029 reset and init high simultaneously with en=1 -> reset behaviour (REQ-019); SEED=0 -> state loads 23'h7FFFFF.
REQ-030 Three instances with seeds 23'h7FF801, 23'h7FF802 and 23'h7FF804 -> identical timing, and their data streams are distinct shifted sequences.
